// File: rtl/vu_meter_pkg.sv
// Shared types, constants and arithmetic helpers for the stereo VU-meter controller.
package vu_meter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    UPD_L = 2'd2,
    UPD_R = 2'd3
  } state_t;

  localparam int LEVEL_W    = 7;
  localparam int PWM_PERIOD = 128;

  // |x| of a signed 8-bit sample; -128 has no positive twin, so it saturates to 127.
  function automatic logic [LEVEL_W-1:0] rectify(input logic [7:0] x);
    if (x == 8'h80)
      rectify = 7'd127;
    else if (x[7])
      rectify = 7'(8'd0 - x);
    else
      rectify = x[6:0];
  endfunction

  // One attack/release step towards avg. The step is never larger than the
  // distance to avg, so the result cannot overshoot and stays in 0..127.
  function automatic logic [LEVEL_W-1:0] ballistic_step(
    input logic [LEVEL_W-1:0] level,
    input logic [LEVEL_W-1:0] avg,
    input int                 attack_shift,
    input int                 release_shift
  );
    logic [LEVEL_W-1:0] diff;
    logic [LEVEL_W-1:0] step;
    ballistic_step = level;
    diff = '0;
    step = '0;
    if (avg > level) begin
      diff = avg - level;
      step = diff >> attack_shift;
      if (step == '0) step = 7'd1;
      ballistic_step = level + step;
    end else if (avg < level) begin
      diff = level - avg;
      step = diff >> release_shift;
      if (step == '0) step = 7'd1;
      ballistic_step = level - step;
    end
  endfunction

endpackage

// File: rtl/vu_pwm_channel.sv
// One meter PWM channel: duty shadow reloaded at period wrap, compare, registered output.
module vu_pwm_channel
  import vu_meter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [LEVEL_W-1:0] period_cnt,
  input  logic [LEVEL_W-1:0] level,
  output logic               pwm
);

  logic [LEVEL_W-1:0] duty;

  // Duty only changes on the wrap tick so a period is never cut short or stretched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) duty <= '0;
    else if (load) duty <= level;
  end

  // Registered compare keeps the meter pin glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm <= 1'b0;
    else pwm <= (period_cnt < duty);
  end

endmodule

// File: rtl/vu_meter_ctrl.sv
// Stereo VU-meter controller: windowed averaging, shared ballistics, dual PWM drive.
module vu_meter_ctrl
  import vu_meter_pkg::*;
#(
  parameter int NUM_AVG       = 16,
  parameter int ATTACK_SHIFT  = 1,
  parameter int RELEASE_SHIFT = 3,
  parameter int PRESCALE      = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               audio_clk_enable,
  input  logic               audio_enable,
  input  logic [7:0]         l_audio_signal,
  input  logic [7:0]         r_audio_signal,
  output logic [LEVEL_W-1:0] l_level,
  output logic [LEVEL_W-1:0] r_level,
  output logic               level_stb,
  output logic               l_VU_pwm,
  output logic               r_VU_pwm
);

  localparam int AVG_SHIFT = $clog2(NUM_AVG);
  localparam int ACC_W     = LEVEL_W + AVG_SHIFT;
  localparam int PRE_W     = $clog2(PRESCALE);

  state_t               state, state_next;
  logic [AVG_SHIFT-1:0] count;
  logic [ACC_W-1:0]     l_acc, r_acc, l_sum, r_sum;
  logic [LEVEL_W-1:0]   l_avg, r_avg;
  logic [LEVEL_W-1:0]   bal_level, bal_avg, bal_next;
  logic                 final_sample;
  logic [PRE_W-1:0]     presc;
  logic [LEVEL_W-1:0]   period_cnt;
  logic                 tick, wrap;

  assign l_sum        = l_acc + ACC_W'(rectify(l_audio_signal));
  assign r_sum        = r_acc + ACC_W'(rectify(r_audio_signal));
  assign final_sample = (state == ACCUM) && audio_clk_enable &&
                        (count == AVG_SHIFT'(NUM_AVG - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_next;
  end

  // Next-state logic; a low enable overrides everything and parks the FSM in IDLE.
  always_comb begin
    state_next = state;
    if (!audio_enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    state_next = ACCUM;
        ACCUM:   if (final_sample) state_next = UPD_L;
        UPD_L:   state_next = UPD_R;
        UPD_R:   state_next = ACCUM;
        default: state_next = IDLE;
      endcase
    end
  end

  // The single ballistics unit is steered to the channel being updated this cycle.
  always_comb begin
    bal_level = l_level;
    bal_avg   = l_avg;
    if (state == UPD_R) begin
      bal_level = r_level;
      bal_avg   = r_avg;
    end
    bal_next = ballistic_step(bal_level, bal_avg, ATTACK_SHIFT, RELEASE_SHIFT);
  end

  // Accumulate, close windows, and write levels; IDLE wipes the partial window and levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      l_acc     <= '0;
      r_acc     <= '0;
      l_avg     <= '0;
      r_avg     <= '0;
      l_level   <= '0;
      r_level   <= '0;
      level_stb <= 1'b0;
    end else if (!audio_enable || state == IDLE) begin
      count     <= '0;
      l_acc     <= '0;
      r_acc     <= '0;
      l_level   <= '0;
      r_level   <= '0;
      level_stb <= 1'b0;
    end else begin
      if (final_sample) begin
        l_avg <= l_sum[ACC_W-1:AVG_SHIFT];
        r_avg <= r_sum[ACC_W-1:AVG_SHIFT];
        l_acc <= '0;
        r_acc <= '0;
        count <= '0;
      end else if (audio_clk_enable) begin
        l_acc <= l_sum;
        r_acc <= r_sum;
        count <= count + AVG_SHIFT'(1);
      end
      if (state == UPD_L) l_level <= bal_next;
      if (state == UPD_R) r_level <= bal_next;
      level_stb <= (state == UPD_R);
    end
  end

  assign tick = (presc == PRE_W'(PRESCALE - 1));
  assign wrap = tick && (period_cnt == LEVEL_W'(PWM_PERIOD - 1));

  // Shared prescaler and period counter; only reset restarts their phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc      <= '0;
      period_cnt <= '0;
    end else if (tick) begin
      presc      <= '0;
      period_cnt <= period_cnt + LEVEL_W'(1);
    end else begin
      presc <= presc + PRE_W'(1);
    end
  end

  vu_pwm_channel u_pwm_l (
    .clk        (clk),
    .rst        (rst),
    .load       (wrap),
    .period_cnt (period_cnt),
    .level      (l_level),
    .pwm        (l_VU_pwm)
  );

  vu_pwm_channel u_pwm_r (
    .clk        (clk),
    .rst        (rst),
    .load       (wrap),
    .period_cnt (period_cnt),
    .level      (r_level),
    .pwm        (r_VU_pwm)
  );

endmodule

// File: tb/tb_vu_meter_ctrl.sv
// Scoreboard bench for vu_meter_ctrl: stimulus pushes expected levels, a monitor checks them on level_stb.
module tb_vu_meter_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       audio_clk_enable = 1'b0;
  logic       audio_enable = 1'b0;
  logic [7:0] l_audio_signal = 8'h00;
  logic [7:0] r_audio_signal = 8'h00;
  logic [6:0] l_level, r_level;
  logic       level_stb, l_VU_pwm, r_VU_pwm;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int hl, hr;
  bit ok;

  typedef struct {
    int l;
    int r;
    int stb_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic prev_stb = 1'b0;

  int atk_half [7]  = '{32, 48, 56, 60, 62, 63, 64};
  int atk_full [9]  = '{63, 95, 111, 119, 123, 125, 126, 127, 127};
  int rel_l    [28] = '{56, 49, 43, 38, 34, 30, 27, 24, 21, 19, 17, 15, 14, 13,
                        12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 0};

  vu_meter_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .audio_clk_enable (audio_clk_enable),
    .audio_enable     (audio_enable),
    .l_audio_signal   (l_audio_signal),
    .r_audio_signal   (r_audio_signal),
    .l_level          (l_level),
    .r_level          (r_level),
    .level_stb        (level_stb),
    .l_VU_pwm         (l_VU_pwm),
    .r_VU_pwm         (r_VU_pwm)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compares every level_stb against the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (sb.size() > 0 && cyc == sb[0].stb_cyc - 1)
        check("l_level_at_N+2", int'(l_level), sb[0].l);
      if (level_stb) begin
        check("stb_single_cycle", int'(prev_stb), 0);
        if (sb.size() == 0) begin
          check("stb_unexpected", int'(level_stb), 0);
        end else begin
          mon_e = sb.pop_front();
          $display("[TB] level_stb cyc=%0d l_level=%0d r_level=%0d", cyc, l_level, r_level);
          check("stb_cycle", cyc, mon_e.stb_cyc);
          check("l_level", int'(l_level), mon_e.l);
          check("r_level", int'(r_level), mon_e.r);
        end
      end
      prev_stb <= level_stb;
    end else begin
      prev_stb <= 1'b0;
    end
  end

  task automatic strobe(input logic [7:0] l, input logic [7:0] r);
    @(negedge clk);
    l_audio_signal   = l;
    r_audio_signal   = r;
    audio_clk_enable = 1'b1;
    @(negedge clk);
    audio_clk_enable = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // 16-strobe window; the final strobe pushes the expectation (or is aborted by reset in UPD_L).
  task automatic run_window(input logic [7:0] l, input logic [7:0] r,
                            input int exp_l, input int exp_r, input bit upd_reset);
    exp_t e;
    for (int i = 0; i < 15; i++) strobe(l, r);
    @(negedge clk);
    l_audio_signal   = l;
    r_audio_signal   = r;
    audio_clk_enable = 1'b1;
    if (!upd_reset) begin
      e.l = exp_l;
      e.r = exp_r;
      e.stb_cyc = cyc + 3;
      sb.push_back(e);
    end
    @(negedge clk);
    audio_clk_enable = 1'b0;
    if (upd_reset) begin
      #2 rst = 1'b1;
      #1;
      check("upd_rst_l_level", int'(l_level), 0);
      check("upd_rst_r_level", int'(r_level), 0);
      check("upd_rst_level_stb", int'(level_stb), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_rise_l(input int limit, output bit found);
    logic prev;
    prev  = l_VU_pwm;
    found = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (l_VU_pwm && !prev) begin
        found = 1'b1;
        break;
      end
      prev = l_VU_pwm;
    end
  endtask

  task automatic count_high(input int n, output int cl, output int cr);
    cl = 0;
    cr = 0;
    for (int i = 0; i < n; i++) begin
      cl += int'(l_VU_pwm);
      cr += int'(r_VU_pwm);
      @(negedge clk);
    end
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_l_level", int'(l_level), 0);
    check("rst_r_level", int'(r_level), 0);
    check("rst_level_stb", int'(level_stb), 0);
    check("rst_l_pwm", int'(l_VU_pwm), 0);
    check("rst_r_pwm", int'(r_VU_pwm), 0);
    rst = 1'b0;
    @(negedge clk);
    audio_enable = 1'b1;

    // Constant 0x40: 32, then 48 mid-period, then 56
    run_window(8'h40, 8'h40, 32, 32, 1'b0);
    wait_rise_l(20000, ok);
    check("pwm_rise_seen", int'(ok), 1);
    fork
      count_high(8192, hl, hr);
      run_window(8'h40, 8'h40, 48, 48, 1'b0);
    join
    check("pwm_l_high_duty32", hl, 2048);
    check("pwm_r_high_duty32", hr, 2048);
    count_high(8192, hl, hr);
    check("pwm_l_high_duty48", hl, 3072);
    check("pwm_r_high_duty48", hr, 3072);
    run_window(8'h40, 8'h40, 56, 56, 1'b0);

    // Disable after 10 strobes: partial window discarded, levels and PWM go to 0
    for (int i = 0; i < 10; i++) strobe(8'h40, 8'h40);
    @(negedge clk);
    audio_enable = 1'b0;
    repeat (2) @(negedge clk);
    check("dis_l_level", int'(l_level), 0);
    check("dis_r_level", int'(r_level), 0);
    repeat (8392) @(negedge clk);
    count_high(8192, hl, hr);
    check("dis_l_pwm_high", hl, 0);
    check("dis_r_pwm_high", hr, 0);

    // Re-enable with left -128 (rectifies to 127): fresh window, climb to 127 and hold
    @(negedge clk);
    audio_enable = 1'b1;
    for (int w = 0; w < 9; w++) run_window(8'h80, 8'h00, atk_full[w], 0, 1'b0);

    // Clear via IDLE, climb to 64, then release with left input 0
    @(negedge clk);
    audio_enable = 1'b0;
    @(negedge clk);
    audio_enable = 1'b1;
    check("idle_l_level", int'(l_level), 0);
    for (int w = 0; w < 7; w++) run_window(8'h40, 8'h40, atk_half[w], atk_half[w], 1'b0);
    for (int w = 0; w < 28; w++) run_window(8'h00, 8'h40, rel_l[w], 64, 1'b0);

    // Reset while the right PWM is high
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (r_VU_pwm) begin
        ok = 1'b1;
        break;
      end
    end
    check("r_pwm_high_seen", int'(ok), 1);
    #2 rst = 1'b1;
    #1;
    check("pwmrst_r_pwm", int'(r_VU_pwm), 0);
    check("pwmrst_l_pwm", int'(l_VU_pwm), 0);
    check("pwmrst_r_level", int'(r_level), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_window(8'h40, 8'h40, 32, 32, 1'b0);

    // Reset during UPD_L, then a fresh start from IDLE
    run_window(8'h40, 8'h40, 0, 0, 1'b1);
    run_window(8'h40, 8'h40, 32, 32, 1'b0);

    repeat (20) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
